// File: rtl/alu_op_controller_pkg.sv
// Shared constants, FSM state type and opcode decode helper for the ALU op controller.
package alu_op_controller_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_MOV = 3'b010;
  localparam logic [2:0] SEL_AND = 3'b100;
  localparam logic [2:0] SEL_ORR = 3'b101;
  localparam logic [2:0] SEL_EOR = 3'b110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] opsel;
    logic       writes_rd;
    logic       arith;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [3:0] cmd);
    op_info_t info;
    info = '{legal: 1'b1, opsel: SEL_ADD, writes_rd: 1'b0, arith: 1'b0};
    case (cmd)
      OP_AND: begin info.opsel = SEL_AND; info.writes_rd = 1'b1; end
      OP_EOR: begin info.opsel = SEL_EOR; info.writes_rd = 1'b1; end
      OP_SUB: begin info.opsel = SEL_SUB; info.writes_rd = 1'b1; info.arith = 1'b1; end
      OP_ADD: begin info.opsel = SEL_ADD; info.writes_rd = 1'b1; info.arith = 1'b1; end
      OP_TST: info.opsel = SEL_AND;
      OP_TEQ: info.opsel = SEL_EOR;
      OP_CMP: begin info.opsel = SEL_SUB; info.arith = 1'b1; end
      OP_CMN: begin info.opsel = SEL_ADD; info.arith = 1'b1; end
      OP_ORR: begin info.opsel = SEL_ORR; info.writes_rd = 1'b1; end
      OP_MOV: begin info.opsel = SEL_MOV; info.writes_rd = 1'b1; end
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/alu_op_controller_cond.sv
// Combinational ARM condition-code evaluator against the {N,Z,C,V} flags.
module cond_check
  import alu_op_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_controller.sv
// Multicycle sequencer: accepts one ARM data-processing request, drives ALU OpSel,
// captures ALU status into NZCV and strobes register write-back.
module alu_op_controller
  import alu_op_controller_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_cmd,
  input  logic [3:0] req_cond,
  input  logic       req_s,
  output logic [2:0] alu_opsel,
  input  logic [3:0] alu_status,
  output logic       rd_we,
  output logic [3:0] flags,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_pass,
  output logic       resp_undef
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cmd_q, cond_q;
  logic       s_q;
  logic [3:0] cnt;
  logic       pass_q, undef_q;
  logic       cond_ok;
  logic       flag_we;
  logic [3:0] flags_nxt;
  op_info_t   info;

  assign info = decode_op(cmd_q);

  cond_check u_cond (
    .cond  (cond_q),
    .flags (flags),
    .pass  (cond_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = (info.legal && cond_ok) ? ST_EXEC : ST_DONE;
      ST_EXEC:   if (cnt == 4'd0) state_nxt = ST_WB;
      ST_WB:     state_nxt = ST_DONE;
      ST_DONE:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_DONE);
    resp_pass  = (state == ST_DONE) && pass_q;
    resp_undef = (state == ST_DONE) && undef_q;
    alu_opsel  = (state == ST_EXEC || state == ST_WB) ? info.opsel : SEL_ADD;
    rd_we      = (state == ST_WB) && info.writes_rd;
    // Compare/test opcodes always update flags; result-producing ones only with S.
    flag_we    = (state == ST_WB) && (s_q || !info.writes_rd);
    flags_nxt  = info.arith ? alu_status
                            : {alu_status[FLAG_N], alu_status[FLAG_Z], flags[FLAG_C], flags[FLAG_V]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      pass_q  <= 1'b0;
      undef_q <= 1'b0;
      flags   <= 4'd0;
    end else begin
      if (state == ST_DECODE) begin
        pass_q  <= info.legal && cond_ok;
        undef_q <= !info.legal;
        cnt     <= CNT_INIT;
      end else if (state == ST_EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (flag_we) flags <= flags_nxt;
    end
  end

  // Request fields are pure data and only meaningful after a handshake.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid) begin
      cmd_q  <= req_cmd;
      cond_q <= req_cond;
      s_q    <= req_s;
    end
  end

endmodule

// File: tb/tb_alu_op_controller.sv
// Self-checking bench for alu_op_controller: directed table, reset/stall sequences, random ops vs model.
module tb_alu_op_controller;

  localparam int E = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_s;
  logic [3:0] req_cmd, req_cond;
  logic [2:0] alu_opsel;
  logic [3:0] alu_status;
  logic       rd_we;
  logic [3:0] flags;
  logic       resp_valid, resp_ready, resp_pass, resp_undef;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags;

  alu_op_controller #(.EXEC_CYCLES(E)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_cond   (req_cond),
    .req_s      (req_s),
    .alu_opsel  (alu_opsel),
    .alu_status (alu_status),
    .rd_we      (rd_we),
    .flags      (flags),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_pass  (resp_pass),
    .resp_undef (resp_undef)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] cmd;
    logic [3:0] cond;
    logic       s;
    logic [3:0] st;
    int         hold;
    logic [3:0] e_flags;
    logic       e_pass;
    logic       e_undef;
    logic       e_we;
    logic [2:0] e_opsel;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from the ARM rules: opcode table, condition pairs, flag classes.
  task automatic model(input logic [3:0] c, input logic [3:0] cd, input logic s, input logic [3:0] st,
                       output logic e_pass, output logic e_undef, output logic e_we,
                       output logic [2:0] e_opsel);
    logic legal, wr, arith, base, ok;
    logic n, z, cf, v;
    legal = 1'b1; wr = 1'b1; arith = 1'b0; e_opsel = 3'b000;
    case (c)
      4'h0: e_opsel = 3'b100;
      4'h1: e_opsel = 3'b110;
      4'h2: begin e_opsel = 3'b001; arith = 1'b1; end
      4'h4: begin e_opsel = 3'b000; arith = 1'b1; end
      4'h8: begin e_opsel = 3'b100; wr = 1'b0; end
      4'h9: begin e_opsel = 3'b110; wr = 1'b0; end
      4'hA: begin e_opsel = 3'b001; wr = 1'b0; arith = 1'b1; end
      4'hB: begin e_opsel = 3'b000; wr = 1'b0; arith = 1'b1; end
      4'hC: e_opsel = 3'b101;
      4'hD: e_opsel = 3'b010;
      default: legal = 1'b0;
    endcase
    n = mflags[3]; z = mflags[2]; cf = mflags[1]; v = mflags[0];
    case (cd[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    ok = cd[0] ? !base : base;
    if (cd == 4'hF) ok = 1'b0;
    e_undef = !legal;
    e_pass  = legal && ok;
    e_we    = e_pass && wr;
    if (e_pass && (s || !wr))
      mflags = arith ? st : {st[3:2], mflags[1:0]};
  endtask

  task automatic do_op(input string tag, input logic [3:0] c, input logic [3:0] cd, input logic s,
                       input logic [3:0] st, input int hold, input logic [3:0] e_flags,
                       input logic e_pass, input logic e_undef, input logic e_we,
                       input logic [2:0] e_opsel);
    int w, k, seq_bad, busy_bad, e_lat;
    logic [2:0] op_k;
    logic we_k;
    e_lat = e_pass ? E + 2 : 1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready_wait"}, 32'(w < 20), 32'd1);
    req_valid = 1'b1; req_cmd = c; req_cond = cd; req_s = s; alu_status = st;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_cmd = 4'($urandom); req_cond = 4'($urandom); req_s = 1'($urandom);
    k = 0; seq_bad = 0; busy_bad = 0;
    while (k < 40) begin
      k++;
      op_k = (e_pass && k >= 2 && k <= E + 2) ? e_opsel : 3'b000;
      we_k = e_we && (k == E + 2);
      if (alu_opsel !== op_k || rd_we !== we_k) seq_bad++;
      if (req_ready !== 1'b0) busy_bad++;
      if (resp_valid) break;
      @(posedge clk); #1;
    end
    check({tag, "_latency"}, 32'(k - 1), 32'(e_lat));
    check({tag, "_opsel_we_seq"}, 32'(seq_bad), 32'd0);
    check({tag, "_ready_busy"}, 32'(busy_bad), 32'd0);
    check({tag, "_pass"}, 32'(resp_pass), 32'(e_pass));
    check({tag, "_undef"}, 32'(resp_undef), 32'(e_undef));
    check({tag, "_flags"}, 32'(flags), 32'(e_flags));
    busy_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_pass !== e_pass) busy_bad++;
    end
    if (hold > 0) check({tag, "_hold_done"}, 32'(busy_bad), 32'd0);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_resp_hs"}, {30'd0, resp_valid, req_ready}, 32'b01);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    logic ep, eu, ew;
    logic [2:0] eo;
    logic [3:0] c, cd, st;
    logic s;
    int we_seen;

    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 4'd0; req_cond = 4'd0; req_s = 1'b0;
    alu_status = 4'd0; resp_ready = 1'b0;
    #12;
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_outs", {25'd0, alu_opsel, rd_we, resp_valid, resp_pass, resp_undef}, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    vt[0]  = '{4'b0100, 4'b1110, 1'b1, 4'b0100, 0, 4'b0100, 1'b1, 1'b0, 1'b1, 3'b000};
    vt[1]  = '{4'b1010, 4'b1110, 1'b0, 4'b0110, 5, 4'b0110, 1'b1, 1'b0, 1'b0, 3'b001};
    vt[2]  = '{4'b0010, 4'b0000, 1'b0, 4'b1111, 0, 4'b0110, 1'b1, 1'b0, 1'b1, 3'b001};
    vt[3]  = '{4'b1000, 4'b1110, 1'b0, 4'b0000, 0, 4'b0010, 1'b1, 1'b0, 1'b0, 3'b100};
    vt[4]  = '{4'b0100, 4'b0000, 1'b1, 4'b1111, 0, 4'b0010, 1'b0, 1'b0, 1'b0, 3'b000};
    vt[5]  = '{4'b1011, 4'b1110, 1'b0, 4'b0011, 0, 4'b0011, 1'b1, 1'b0, 1'b0, 3'b000};
    vt[6]  = '{4'b1100, 4'b1110, 1'b1, 4'b1000, 0, 4'b1011, 1'b1, 1'b0, 1'b1, 3'b101};
    vt[7]  = '{4'b0111, 4'b1110, 1'b1, 4'b1111, 0, 4'b1011, 1'b0, 1'b1, 1'b0, 3'b000};
    vt[8]  = '{4'b1101, 4'b1111, 1'b1, 4'b0000, 0, 4'b1011, 1'b0, 1'b0, 1'b0, 3'b010};
    vt[9]  = '{4'b0001, 4'b1010, 1'b1, 4'b0100, 0, 4'b0111, 1'b1, 1'b0, 1'b1, 3'b110};
    vt[10] = '{4'b1001, 4'b1011, 1'b0, 4'b1000, 0, 4'b1011, 1'b1, 1'b0, 1'b0, 3'b110};
    vt[11] = '{4'b0000, 4'b1000, 1'b0, 4'b0100, 2, 4'b1011, 1'b1, 1'b0, 1'b1, 3'b100};
    vt[12] = '{4'b0010, 4'b1001, 1'b1, 4'b0000, 0, 4'b1011, 1'b0, 1'b0, 1'b0, 3'b001};

    for (int i = 0; i < 13; i++)
      do_op($sformatf("vec%0d", i), vt[i].cmd, vt[i].cond, vt[i].s, vt[i].st, vt[i].hold,
            vt[i].e_flags, vt[i].e_pass, vt[i].e_undef, vt[i].e_we, vt[i].e_opsel);

    // Reset asserted while an ADD S=1 sits in EXEC.
    req_valid = 1'b1; req_cmd = 4'b0100; req_cond = 4'b1110; req_s = 1'b1; alu_status = 4'b0100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_busy", 32'(req_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_ready", 32'(req_ready), 32'd1);
    check("rst_async_flags", 32'(flags), 32'd0);
    check("rst_async_outs", {25'd0, alu_opsel, rd_we, resp_valid, resp_pass, resp_undef}, 32'd0);
    we_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rd_we || !req_ready) we_seen++;
    end
    check("rst_no_we", 32'(we_seen), 32'd0);
    @(negedge clk);
    mflags = 4'd0;

    for (int i = 0; i < 40; i++) begin
      c  = 4'($urandom);
      cd = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
      s  = 1'($urandom);
      st = 4'($urandom);
      model(c, cd, s, st, ep, eu, ew, eo);
      do_op($sformatf("rnd%0d", i), c, cd, s, st, $urandom_range(0, 2), mflags, ep, eu, ew, eo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_controller.md
Name: alu_op_controller

Overview:
- Multicycle sequencer on the controller side of the datapath ALU. It drives the ALU's 3-bit OpSel and consumes its {N,Z,CO,OVF} status.
- Accepts one ARM data-processing request per handshake, checks the 4-bit condition field against an internal NZCV flag register, and sequences the ALU.
- Captures ALU status, updates flags when S is set, and asserts register write-back when the opcode produces a result.

Parameters:
- EXEC_CYCLES, 1, ALU settle cycles spent in EXEC (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller idle, accepts request
- req_cmd  in  4  ARM DP opcode, instr[24:21]
- req_cond  in  4  condition field, instr[31:28]
- req_s  in  1  S bit
- alu_opsel  out  3  to ALU OpSel
- alu_status  in  4  from ALU {N,Z,CO,OVF}
- rd_we  out  1  one-cycle register-file write strobe
- flags  out  4  current {N,Z,C,V}
- resp_valid  out  1  operation finished
- resp_ready  in  1  response consumed
- resp_pass  out  1  condition passed and opcode legal
- resp_undef  out  1  opcode unsupported

Behaviour:
- Reset: state IDLE; flags=0000; alu_opsel=000; rd_we=0; resp_valid=0; resp_pass=0; resp_undef=0; req_ready=1.
- Opcode map (cmd -> opsel, writes Rd, flag class):
  - AND 0000 -> 100, yes, logic
  - EOR 0001 -> 110, yes, logic
  - SUB 0010 -> 001, yes, arith
  - ADD 0100 -> 000, yes, arith
  - TST 1000 -> 100, no, logic
  - TEQ 1001 -> 110, no, logic
  - CMP 1010 -> 001, no, arith
  - CMN 1011 -> 000, no, arith
  - ORR 1100 -> 101, yes, logic
  - MOV 1101 -> 010, yes, logic
  - Any other opcode is undef.
- Condition codes:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL (1110) always passes; 1111 never passes.
  - Evaluated against the flags register value at DECODE.
- FSM:
  - IDLE: req_ready=1. On req_valid, latch cmd/cond/s and go to DECODE. The handshake completes in the same cycle.
  - DECODE: compute pass and undef. If undef or !pass, go to DONE. Otherwise load the settle counter with EXEC_CYCLES-1 and go to EXEC.
  - EXEC: alu_opsel holds the mapped code. Count down; at zero go to WB.
  - WB:
    - alu_opsel is still held; alu_status is sampled this cycle.
    - rd_we=1 for this single cycle if the opcode writes Rd.
    - Flag write happens if S=1, or always for TST/TEQ/CMP/CMN.
    - Arith class: flags<=alu_status. Logic class: N,Z<=alu_status[3:2] and C,V are kept.
    - Go to DONE.
  - DONE: resp_valid=1; resp_pass and resp_undef are stable. On resp_ready, go to IDLE.
- req_ready=0 in every state other than IDLE. req_valid while busy is ignored.
- alu_opsel=000 outside EXEC/WB.
- The flags output reflects the register; an update is visible the cycle after WB.
- Minimum latency, request accept to resp_valid: DECODE + EXEC_CYCLES + WB = EXEC_CYCLES+2 cycles. With a condition fail or undef it is 1 cycle.
- Back-to-back operation: a request in the cycle after resp handshake sees the already-updated flags.
- rst_n is asserted asynchronously at any state. The machine returns to IDLE, flags clear, and no rd_we is emitted. The in-flight op is lost.

Decomposition:
- Shared package holds:
  - ARM DP opcode constants.
  - Condition-code constants.
  - ALU OpSel constants (ADD 000, SUB 001, MOV 010, AND 100, ORR 101, EOR 110).
  - FSM state enum.
  - Status bit indices N=3, Z=2, C=1, V=0.
- One sub-module: cond_check, purely combinational: cond[3:0], flags[3:0] -> pass.

Test Plan:
- Reset, then ADD S=1 cond=AL with the ALU model returning 0100 -> opsel 000 in EXEC, rd_we pulse in WB, flags=0100, resp_pass=1, resp_valid at accept+3 (EXEC_CYCLES=1).
- CMP cond=AL with status 0110 -> rd_we never asserted, flags=0110. Follow with SUB cond=EQ (Z=1) -> passes, rd_we=1.
- With flags=0000, issue ADD cond=EQ -> DECODE→DONE directly, resp_pass=0, no rd_we, opsel stays 000, flags unchanged.
- Flags 0011, ORR S=1 with status 1000 -> flags=1011 (C,V preserved), opsel 101.
- cmd=0111 (RSC) -> resp_undef=1, resp_pass=0, no write.
- rst_n low during EXEC of ADD S=1 -> immediately IDLE, req_ready=1, flags=0000, no rd_we. Hold resp_ready=0 in DONE for 5 cycles -> resp_valid stays 1 and req_ready stays 0.
